ecp5pll_phase_ctrl: RTL and testbench

Dynamic phase-shift sequencer for the `ecp5pll` wrapper. It accepts phase-adjust commands on a valid/ready handshake and converts them into correctly timed `phasesel`/`phasedir`/`phasestep`/`phaseloadreg` waveforms. It gates operation on a synchronized `locked` and reports completion or abort. It sits between control logic (e.g. a DDR/SDRAM read-capture calibration engine) and the PLL's dynamic-phase ports. The PLL is instantiated with `dynamic_en=1`.

---
 rtl/ecp5pll_pkg.sv | 35 +++
 rtl/ecp5pll_phase_ctrl_sync2.sv | 22 ++
 rtl/ecp5pll_phase_ctrl.sv | 125 ++++++++++++
 tb/tb_ecp5pll_phase_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecp5pll_pkg.sv
// Shared types and default timing for the ECP5 PLL dynamic phase-shift sequencer.
// The calibration engine imports the same defaults so both sides agree on command cost.
package ecp5pll_pkg;

  localparam int DEF_SETUP_CYC = 4;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_GAP_CYC   = 8;
  localparam int DEF_STEP_W    = 8;

  // Widest step field a command can carry; STEP_W must not exceed this.
  localparam int CMD_STEPS_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE,
    ABORT
  } phase_state_e;

  typedef struct packed {
    logic [1:0]             sel;
    logic                   dir;
    logic                   load;
    logic [CMD_STEPS_W-1:0] steps;
  } phase_cmd_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ecp5pll_phase_ctrl_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset; output is 0 out of reset.
module sync2 (
  input  logic clk_i,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments so both flops sample the pre-edge values and form a real 2-stage chain.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Turns phase-adjust commands into timed phasesel/phasedir/phasestep/phaseloadreg waveforms
// for the ecp5pll dynamic-phase ports, aborting cleanly when the PLL loses lock.
module ecp5pll_phase_ctrl
  import ecp5pll_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int STEP_W    = DEF_STEP_W
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic              req_load,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              pll_locked,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  output logic              done,
  output logic              err,
  output logic              locked_sync,
  output logic              busy
);

  localparam int TMR_W = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);

  typedef logic [TMR_W-1:0] tmr_t;

  localparam tmr_t SETUP_LD = tmr_t'(SETUP_CYC - 1);
  localparam tmr_t PULSE_LD = tmr_t'(PULSE_CYC - 1);
  localparam tmr_t GAP_LD   = tmr_t'(GAP_CYC - 1);

  phase_state_e state, next_state;
  tmr_t         tmr;
  phase_cmd_t   cmd;
  logic         accept;

  sync2 u_lock_sync (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_sync)
  );

  assign req_ready = (state == IDLE) && locked_sync;
  assign accept    = req_valid && req_ready;

  // Select and direction come straight from the latched command, so they cannot move mid-command.
  assign phasesel = cmd.sel;
  assign phasedir = cmd.dir;

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SETUP;
      end
      SETUP: begin
        if (!locked_sync)                       next_state = ABORT;
        else if (tmr == '0)                     next_state = (cmd.load || cmd.steps != '0) ? PULSE : GAP;
      end
      PULSE: begin
        if (!locked_sync)                       next_state = ABORT;
        else if (tmr == '0)                     next_state = GAP;
      end
      GAP: begin
        if (!locked_sync)                       next_state = ABORT;
        else if (tmr == '0)                     next_state = (cmd.steps != '0 && !cmd.load) ? PULSE : DONE;
      end
      DONE:    next_state = IDLE;
      ABORT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tmr          <= '0;
      cmd          <= '0;
      phasestep    <= 1'b0;
      phaseloadreg <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state <= next_state;

      // Every state change reloads the timer for the state being entered.
      if (next_state != state) begin
        case (next_state)
          SETUP:   tmr <= SETUP_LD;
          PULSE:   tmr <= PULSE_LD;
          GAP:     tmr <= GAP_LD;
          default: tmr <= '0;
        endcase
      end else if (tmr != '0) begin
        tmr <= tmr - tmr_t'(1);
      end

      if (accept) begin
        cmd.sel   <= req_sel;
        cmd.dir   <= req_dir;
        cmd.load  <= req_load;
        cmd.steps <= CMD_STEPS_W'(req_steps);
      end else if (state == PULSE && next_state != PULSE && cmd.steps != '0) begin
        cmd.steps <= cmd.steps - CMD_STEPS_W'(1);
      end

      // Outputs are decoded from next_state so they line up with the state they describe.
      phasestep    <= (next_state == PULSE) && !cmd.load;
      phaseloadreg <= (next_state == PULSE) &&  cmd.load;
      done         <= (next_state == DONE) || (next_state == ABORT);
      err          <= (next_state == ABORT);
      busy         <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Randomized bench for ecp5pll_phase_ctrl: every cycle of every command is compared against
// a timeline model derived from the command timing rules.
module tb_ecp5pll_phase_ctrl;

  localparam int S  = 4;
  localparam int P  = 4;
  localparam int G  = 8;
  localparam int SW = 8;

  logic          clk_i      = 1'b0;
  logic          reset_n    = 1'b0;
  logic          req_valid  = 1'b0;
  logic [1:0]    req_sel    = '0;
  logic          req_dir    = 1'b0;
  logic          req_load   = 1'b0;
  logic [SW-1:0] req_steps  = '0;
  logic          pll_locked = 1'b1;
  logic          req_ready;
  logic [1:0]    phasesel;
  logic          phasedir, phasestep, phaseloadreg, done, err, locked_sync, busy;

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] sel;
    logic       dir;
    logic       load;
    int         steps;
  } cmd_t;

  ecp5pll_phase_ctrl #(
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .GAP_CYC   (G),
    .STEP_W    (SW)
  ) dut (
    .clk_i        (clk_i),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_load     (req_load),
    .req_steps    (req_steps),
    .pll_locked   (pll_locked),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .done         (done),
    .err          (err),
    .locked_sync  (locked_sync),
    .busy         (busy)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (ready,busy,sel,dir,step,load,done,err) cycle %0d",
               tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [8:0] observed();
    return {req_ready, busy, phasesel, phasedir, phasestep, phaseloadreg, done, err};
  endfunction

  function automatic cmd_t mk(input int sel, input int dir, input int load, input int steps);
    cmd_t c;
    c.sel   = 2'(sel);
    c.dir   = 1'(dir);
    c.load  = 1'(load);
    c.steps = steps;
    return c;
  endfunction

  // Cycle (relative to the accept cycle) on which done is expected.
  function automatic int done_rel(input cmd_t c);
    if (c.load)        return 1 + S + P + G;
    if (c.steps == 0)  return 1 + S + G;
    return 1 + S + c.steps * (P + G);
  endfunction

  // Expected outputs at cycle rel after accept; abort_rel > 0 means lock is lost and stays lost.
  function automatic logic [8:0] model(input cmd_t c, input int rel, input int abort_rel);
    logic rdy, bsy, stp, ldr, dn, er;
    int   d, n, k0;
    d   = done_rel(c);
    n   = c.load ? 1 : c.steps;
    stp = 1'b0;
    ldr = 1'b0;
    if (abort_rel > 0 && rel >= abort_rel) begin
      rdy = 1'b0;
      bsy = (rel == abort_rel);
      dn  = bsy;
      er  = bsy;
    end else begin
      rdy = (rel > d);
      bsy = (rel <= d);
      dn  = (rel == d);
      er  = 1'b0;
      for (int k = 0; k < n; k++) begin
        k0 = 1 + S + k * (P + G);
        if (rel >= k0 && rel < k0 + P) begin
          if (c.load) ldr = 1'b1;
          else        stp = 1'b1;
        end
      end
    end
    return {rdy, bsy, c.sel, c.dir, stp, ldr, dn, er};
  endfunction

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (!req_ready) check({tag, " ready_timeout"}, 9'(req_ready), 9'd1);
  endtask

  // Issues c at a negedge and checks every cycle through the one after done (or abort).
  // hold keeps req_valid high with random fields while busy; drop_rel > 0 drops lock then.
  task automatic run_cmd(input string tag, input cmd_t c, input bit hold, input int drop_rel);
    int abort_rel, last;
    wait_ready(tag);
    req_valid = 1'b1;
    req_sel   = c.sel;
    req_dir   = c.dir;
    req_load  = c.load;
    req_steps = SW'(c.steps);
    abort_rel = (drop_rel > 0) ? drop_rel + 3 : 0;
    last      = (drop_rel > 0) ? abort_rel + 1 : done_rel(c) + 1;
    for (int rel = 1; rel <= last; rel++) begin
      @(negedge clk_i);
      check($sformatf("%s rel%0d", tag, rel), observed(), model(c, rel, abort_rel));
      if (hold) begin
        req_valid = 1'b1;
        req_sel   = 2'($urandom_range(0, 3));
        req_dir   = 1'($urandom_range(0, 1));
        req_load  = 1'($urandom_range(0, 1));
        req_steps = SW'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      if (rel == drop_rel) pll_locked = 1'b0;
    end
  endtask

  // Restores lock after a drop and checks the 2-cycle resynchronization before ready returns.
  task automatic relock(input string tag);
    repeat (2) begin
      @(negedge clk_i);
      check({tag, " lock_low"}, 9'(req_ready), 9'd0);
    end
    pll_locked = 1'b1;
    @(negedge clk_i);
    check({tag, " relock1"}, 9'(req_ready), 9'd0);
    @(negedge clk_i);
    check({tag, " relock2"}, 9'(req_ready), 9'd1);
  endtask

  initial begin
    cmd_t c;
    int   drop;

    // Reset with lock present: everything 0, ready only after the synchronizer fills.
    repeat (3) @(negedge clk_i);
    check("reset_outputs", observed(), 9'd0);
    reset_n = 1'b1;
    @(negedge clk_i);
    check("sync_lat1", observed(), 9'd0);
    @(negedge clk_i);
    check("sync_lat2", observed(), 9'b1_0000_0000);

    run_cmd("sel2_steps3", mk(2, 1, 0, 3), 1'b0, 0);
    run_cmd("steps0",      mk(1, 0, 0, 0), 1'b0, 0);
    run_cmd("load5",       mk(3, 1, 1, 5), 1'b0, 0);
    run_cmd("load0",       mk(0, 0, 1, 0), 1'b0, 0);
    run_cmd("max_sel1",    mk(3, 0, 0, 1), 1'b0, 0);

    // Valid held high through a busy command; the follow-up is accepted the cycle after done.
    run_cmd("hold_first",  mk(0, 1, 0, 2), 1'b1, 0);
    run_cmd("hold_second", mk(3, 0, 0, 1), 1'b0, 0);

    // Lock lost on the first cycle of the second pulse of a 10-step command.
    run_cmd("lockdrop", mk(1, 1, 0, 10), 1'b0, 1 + S + (P + G));
    relock("lockdrop");

    for (int i = 0; i < 40; i++) begin
      c = mk($urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) begin
        drop = $urandom_range(1, done_rel(c) - 3);
        run_cmd($sformatf("rnd%0d_drop", i), c, 1'b0, drop);
        relock($sformatf("rnd%0d", i));
      end else begin
        run_cmd($sformatf("rnd%0d", i), c, ($urandom_range(0, 3) == 0), 0);
      end
    end

    // Asynchronous reset in the middle of a pulse clears outputs at once, with no done.
    wait_ready("midreset");
    req_valid = 1'b1;
    req_sel   = 2'd2;
    req_dir   = 1'b1;
    req_load  = 1'b0;
    req_steps = SW'(4);
    @(negedge clk_i);
    req_valid = 1'b0;
    repeat (6) @(negedge clk_i);
    check("midreset_pulse", 9'(phasestep), 9'd1);
    #1 reset_n = 1'b0;
    #1 check("midreset_async", observed(), 9'd0);
    @(negedge clk_i);
    check("midreset_held", observed(), 9'd0);
    reset_n = 1'b1;
    @(negedge clk_i);
    check("midreset_sync1", observed(), 9'd0);
    @(negedge clk_i);
    check("midreset_sync2", observed(), 9'b1_0000_0000);

    run_cmd("after_reset", mk(2, 0, 0, 2), 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
